// File: rtl/bit_debouncer_pkg.sv
// Shared types and defaults for the bit debouncer family.
// One package keeps every debouncer instance on the same timing default.
package bit_debouncer_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

    // 1 ms at the 1 MHz board clock
    localparam int unsigned DEF_STABLE_CYCLES = 1000;

endpackage

// File: rtl/bit_debouncer_edge_pulse.sv
// Registered rise/fall detector for the debounced level.
// Compares the level about to be stored against the current one.
module bit_debouncer_edge_pulse (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic level,
    input  logic level_nxt,
    output logic rise_out,
    output logic fall_out
);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rise_out <= 1'b0;
            fall_out <= 1'b0;
        end else begin
            rise_out <= level_nxt & ~level;
            fall_out <= ~level_nxt & level;
        end
    end

endmodule

// File: rtl/bit_debouncer.sv
// Debouncer for a single bit already synchronous to clk_in.
// Emits a stable level, edge pulses and a saturating event count.
module bit_debouncer
    import bit_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned EVT_WIDTH     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 bit_in,
    input  logic                 clr_in,
    output logic                 level_out,
    output logic                 rise_out,
    output logic                 fall_out,
    output logic [EVT_WIDTH-1:0] evt_count
);

    localparam int unsigned CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    db_state_t            state_q;
    db_state_t            state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic                 match;
    logic                 done;
    logic                 accept;
    logic                 level_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            level_out <= INIT_LEVEL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_out <= level_d;
        end
    end

    // Only a PENDING run carries a partial count.
    always_comb begin
        match    = (bit_in == level_out);
        cnt_base = (state_q == PENDING) ? cnt_q : '0;
        done     = (cnt_base == CNT_LAST);
        state_d  = (match || done) ? STABLE : PENDING;
    end

    always_comb begin
        accept  = !match && done;
        cnt_d   = (match || done) ? '0 : cnt_base + CNT_WIDTH'(1);
        level_d = accept ? bit_in : level_out;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            evt_count <= '0;
        end else if (clr_in) begin
            evt_count <= '0;
        end else if (accept && !(&evt_count)) begin
            evt_count <= evt_count + EVT_WIDTH'(1);
        end
    end

    bit_debouncer_edge_pulse u_edge (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .level     (level_out),
        .level_nxt (level_d),
        .rise_out  (rise_out),
        .fall_out  (fall_out)
    );

endmodule

// File: tb/tb_bit_debouncer.sv
// Bench for bit_debouncer: a 4-sample build and a 1-sample build,
// both checked every cycle against a sample-history reference model.
module tb_bit_debouncer;

    localparam int N = 4;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b1;
    logic       bit_in = 1'b0;
    logic       clr_in = 1'b0;
    logic       level_out;
    logic       rise_out;
    logic       fall_out;
    logic [3:0] evt_count;

    logic       bit1 = 1'b0;
    logic       clr1 = 1'b0;
    logic       level1;
    logic       rise1;
    logic       fall1;
    logic [3:0] evt1;

    int n_checks = 0;
    int n_errors = 0;

    bit hist[$];
    bit m_lvl;
    int m_evt;
    bit m_lvl1;
    int m_evt1;

    always #5 clk_in = ~clk_in;

    bit_debouncer #(
        .STABLE_CYCLES (N),
        .INIT_LEVEL    (1'b0),
        .EVT_WIDTH     (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .bit_in    (bit_in),
        .clr_in    (clr_in),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .evt_count (evt_count)
    );

    bit_debouncer #(
        .STABLE_CYCLES (1),
        .INIT_LEVEL    (1'b0),
        .EVT_WIDTH     (4)
    ) dut1 (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .bit_in    (bit1),
        .clr_in    (clr1),
        .level_out (level1),
        .rise_out  (rise1),
        .fall_out  (fall1),
        .evt_count (evt1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic pulse_reset();
        rst_n_in = 1'b0;
        #2;
        hist.delete();
        m_lvl  = 1'b0;
        m_evt  = 0;
        m_lvl1 = 1'b0;
        m_evt1 = 0;
        chk("rst_level", level_out, 0);
        chk("rst_rise", rise_out, 0);
        chk("rst_fall", fall_out, 0);
        chk("rst_evt", evt_count, 0);
        chk("rst_level1", level1, 0);
        chk("rst_evt1", evt1, 0);
        #1;
        rst_n_in = 1'b1;
    endtask

    // Accept once the last N samples since reset all differ from the level.
    task automatic step(input logic b, input logic c);
        bit acc;
        bit acc1;
        bit e_rise;
        bit e_fall;
        bit e_rise1;
        bit e_fall1;
        bit_in = b;
        clr_in = c;
        bit1   = ~bit1;
        @(posedge clk_in);
        hist.push_back(b);
        if (hist.size() > N) void'(hist.pop_front());
        acc = (hist.size() == N);
        for (int i = 0; i < hist.size(); i++)
            if (hist[i] == m_lvl) acc = 1'b0;
        e_rise = acc && b;
        e_fall = acc && !b;
        if (acc) m_lvl = b;
        if (c) m_evt = 0;
        else if (acc && m_evt != 15) m_evt++;

        acc1    = (bit1 != m_lvl1);
        e_rise1 = acc1 && bit1;
        e_fall1 = acc1 && !bit1;
        if (acc1) m_lvl1 = bit1;
        if (acc1 && m_evt1 != 15) m_evt1++;
        #1;
        chk("level", level_out, m_lvl);
        chk("rise", rise_out, e_rise);
        chk("fall", fall_out, e_fall);
        chk("evt", evt_count, m_evt);
        chk("level1", level1, m_lvl1);
        chk("rise1", rise1, e_rise1);
        chk("fall1", fall1, e_fall1);
        chk("evt1", evt1, m_evt1);
    endtask

    initial begin
        logic v;
        logic pb;
        #1;
        bit_in = 1'b1;
        pulse_reset();

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("s1_pre_level", level_out, 0);
        step(1'b1, 1'b0);
        chk("s1_level", level_out, 1);
        chk("s1_rise", rise_out, 1);
        chk("s1_evt", evt_count, 1);
        step(1'b1, 1'b0);
        chk("s1_rise_drop", rise_out, 0);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("fall_pulse", fall_out, 1);
        chk("fall_evt", evt_count, 2);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("glitch_level", level_out, 0);
        step(1'b0, 1'b0);

        v = 1'b1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) step(v, 1'b0);
            v = ~v;
        end
        chk("sat_evt", evt_count, 15);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("clr_evt", evt_count, 0);
        chk("clr_rise", rise_out, 1);

        for (int i = 0; i < N; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("rstmid_level", level_out, 0);
        step(1'b1, 1'b0);
        chk("rstmid_accept", level_out, 1);

        pb = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            step(pb, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
